// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared definitions for the switch-loaded bit-serial adder.
// Holds the controller state encoding (also driven to the LEDs) and the
// default operand width and button debounce length.
package adder_seq_pkg;

  localparam int WIDTH_DEFAULT    = 7;
  localparam int DEBOUNCE_DEFAULT = 16;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    LOAD_A_LO = 3'd0,
    LOAD_A_HI = 3'd1,
    LOAD_B_LO = 3'd2,
    LOAD_B_HI = 3'd3,
    ADD       = 3'd4,
    DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell, time-shared by the sequencer.
// Ports: a, b, cin -> sum, cout.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pb_debounce.sv
// pb_debounce: conditions one raw push button.
// Ports: clk, rst_n (sync, active-low), raw (asynchronous bouncy input),
//        pulse (one-cycle pulse on each accepted press).
// The raw level is synchronised through two flops; the accepted level only
// follows it after DEBOUNCE_CYCLES consecutive samples that differ from it.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          pulse_r;

  // Synchroniser, stability counter and rising-edge pulse of the accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= '0;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      pulse_r <= 1'b0;
      if (sync2_r == level_r) begin
        // Any sample agreeing with the accepted level restarts the count.
        cnt_r <= '0;
      end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_r <= sync2_r;
        cnt_r   <= '0;
        pulse_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/adder_load_sequencer.sv
// adder_load_sequencer: loads two WIDTH-bit operands from 4-bit switches with
// a single "next" button (low nibble then high part, A then B) and adds them
// bit-serially through one full_adder over WIDTH cycles.
// Ports: clk, rst_n (sync, active-low), pb_next / pb_clear (raw buttons),
//        y (switches) -> z (sum), carry (MSB carry-out), busy (in ADD),
//        done (in DONE), state_o (state encoding for LEDs).
module adder_load_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pb_next,
  input  logic             pb_clear,
  input  logic [3:0]       y,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_o
);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] z_r;
  logic [2:0]       cnt_r;
  logic             c_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;

  logic next_pulse;
  logic clear_pulse;
  logic fa_sum;
  logic fa_cout;

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (pb_next),
    .pulse (next_pulse)
  );

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (pb_clear),
    .pulse (clear_pulse)
  );

  // The single adder cell always looks at the bit selected by the counter.
  full_adder u_fa (
    .a    (a_r[cnt_r]),
    .b    (b_r[cnt_r]),
    .cin  (c_r),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Load/add controller; clear has priority over next in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= LOAD_A_LO;
      a_r     <= '0;
      b_r     <= '0;
      z_r     <= '0;
      cnt_r   <= 3'd0;
      c_r     <= 1'b0;
      carry_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (clear_pulse) begin
      state_r <= LOAD_A_LO;
      a_r     <= '0;
      b_r     <= '0;
      z_r     <= '0;
      cnt_r   <= 3'd0;
      c_r     <= 1'b0;
      carry_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        LOAD_A_LO: begin
          if (next_pulse) begin
            a_r[3:0] <= y;
            state_r  <= LOAD_A_HI;
          end
        end
        LOAD_A_HI: begin
          if (next_pulse) begin
            a_r[WIDTH-1:4] <= y[WIDTH-5:0];
            state_r        <= LOAD_B_LO;
          end
        end
        LOAD_B_LO: begin
          if (next_pulse) begin
            b_r[3:0] <= y;
            state_r  <= LOAD_B_HI;
          end
        end
        LOAD_B_HI: begin
          if (next_pulse) begin
            b_r[WIDTH-1:4] <= y[WIDTH-5:0];
            cnt_r          <= 3'd0;
            c_r            <= 1'b0;
            busy_r         <= 1'b1;
            state_r        <= ADD;
          end
        end
        ADD: begin
          // z is not pre-cleared; each bit is overwritten in LSB-first order.
          z_r[cnt_r] <= fa_sum;
          c_r        <= fa_cout;
          if (cnt_r == 3'(WIDTH - 1)) begin
            carry_r <= fa_cout;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        DONE: begin
          if (next_pulse) begin
            done_r  <= 1'b0;
            state_r <= LOAD_A_LO;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= LOAD_A_LO;
        end
      endcase
    end
  end

  assign z       = z_r;
  assign carry   = carry_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_adder_load_sequencer.sv
// tb_adder_load_sequencer: self-checking bench for adder_load_sequencer.
// A main instance uses the default debounce length; a second instance with a
// one-sample debounce makes it possible to land next presses inside ADD.
module tb_adder_load_sequencer;

  localparam int W = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, pb_next, pb_clear;
  logic [3:0]   y;
  logic [W-1:0] z;
  logic         carry, busy, done;
  logic [2:0]   state_o;

  logic         rst_nf, pbn_f, pbc_f;
  logic [3:0]   y_f;
  logic [W-1:0] z_f;
  logic         carry_f, busy_f, done_f;
  logic [2:0]   state_f;

  adder_load_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .pb_next(pb_next), .pb_clear(pb_clear), .y(y),
    .z(z), .carry(carry), .busy(busy), .done(done), .state_o(state_o)
  );

  adder_load_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) dut_f (
    .clk(clk), .rst_n(rst_nf), .pb_next(pbn_f), .pb_clear(pbc_f), .y(y_f),
    .z(z_f), .carry(carry_f), .busy(busy_f), .done(done_f), .state_o(state_f)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: operands and results as plain integers.
  int m_state, m_a, m_b, m_z, m_carry;

  task automatic model_clear();
    m_state = 0; m_a = 0; m_b = 0; m_z = 0; m_carry = 0;
  endtask

  task automatic model_next(input logic [3:0] yv);
    int hi_mask;
    int s;
    hi_mask = (1 << (W - 4)) - 1;
    case (m_state)
      0: begin m_a = (m_a & ~15) | int'(yv); m_state = 1; end
      1: begin m_a = (m_a & 15) | ((int'(yv) & hi_mask) << 4); m_state = 2; end
      2: begin m_b = (m_b & ~15) | int'(yv); m_state = 3; end
      3: begin
        m_b = (m_b & 15) | ((int'(yv) & hi_mask) << 4);
        s = m_a + m_b;
        m_z = s % (1 << W);
        m_carry = s / (1 << W);
        m_state = 5;
      end
      5: m_state = 0;
      default: ;
    endcase
  endtask

  // Clean press: hold well past the debounce length, release, settle.
  task automatic press(input logic nxt, input logic clr, input logic [3:0] yv);
    @(negedge clk);
    y = yv; pb_next = nxt; pb_clear = clr;
    repeat (24) @(negedge clk);
    pb_next = 1'b0; pb_clear = 1'b0;
    repeat (24) @(negedge clk);
    if (clr) model_clear();
    else if (nxt) model_next(yv);
    vectors++;
    if (int'(state_o) !== m_state) begin
      miscompares++;
      $display("FAIL press_state: got %0d expected %0d", state_o, m_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pb_next = 1'b0; pb_clear = 1'b0; y = 4'h0;
    rst_nf = 1'b0; pbn_f = 1'b0; pbc_f = 1'b0; y_f = 4'h0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({z, carry, busy, done, state_o} !== {{W{1'b0}}, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset: got z=%0h c=%0b busy=%0b done=%0b st=%0d expected all zero",
               z, carry, busy, done, state_o);
    end
    rst_n = 1'b1; rst_nf = 1'b1;
    model_clear();
  endtask

  task automatic load_and_add(input logic [3:0] alo, input logic [3:0] ahi,
                              input logic [3:0] blo, input logic [3:0] bhi,
                              input string nm);
    int bf, df, bc;
    bf = -1; df = -1; bc = 0;
    if (m_state == 5) press(1'b1, 1'b0, 4'h0);
    press(1'b1, 1'b0, alo);
    press(1'b1, 1'b0, ahi);
    press(1'b1, 1'b0, blo);
    @(negedge clk);
    y = bhi; pb_next = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 24) pb_next = 1'b0;
      if (busy) begin
        bc++;
        if (bf < 0) bf = k;
      end
      if (done && df < 0) df = k;
    end
    model_next(bhi);
    vectors++;
    if (bf < 0 || df < 0) begin
      miscompares++;
      $display("FAIL %s_timeout: busy at %0d done at %0d, expected both seen", nm, bf, df);
    end
    vectors++;
    if (bc != W) begin
      miscompares++;
      $display("FAIL %s_busy_len: got %0d expected %0d", nm, bc, W);
    end
    vectors++;
    if (df - bf != W) begin
      miscompares++;
      $display("FAIL %s_done_latency: got %0d expected %0d", nm, df - bf, W);
    end
    vectors++;
    if (int'(z) !== m_z || int'(carry) !== m_carry) begin
      miscompares++;
      $display("FAIL %s_sum: got z=%0h c=%0b expected z=%0h c=%0d", nm, z, carry, m_z, m_carry);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || int'(state_o) !== m_state) begin
      miscompares++;
      $display("FAIL %s_final: got done=%0b busy=%0b st=%0d expected 1 0 %0d",
               nm, done, busy, state_o, m_state);
    end
  endtask

  task automatic test_random_loads();
    for (int i = 0; i < 4; i++)
      load_and_add(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), "random");
  endtask

  task automatic test_done_return();
    int old_z, old_c;
    old_z = m_z; old_c = m_carry;
    press(1'b1, 1'b0, 4'($urandom));
    vectors++;
    if (int'(z) !== old_z || int'(carry) !== old_c || done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_return_hold: got z=%0h c=%0b done=%0b expected z=%0h c=%0d done=0",
               z, carry, done, old_z, old_c);
    end
  endtask

  task automatic test_glitch_and_hold();
    int changes;
    logic [2:0] prev;
    @(negedge clk);
    y = 4'h9; pb_next = 1'b1;
    repeat (3) @(negedge clk);
    pb_next = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (int'(state_o) !== m_state) begin
      miscompares++;
      $display("FAIL glitch: got state %0d expected %0d", state_o, m_state);
    end
    changes = 0;
    prev = state_o;
    pb_next = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (state_o !== prev) changes++;
      prev = state_o;
    end
    pb_next = 1'b0;
    repeat (30) @(negedge clk);
    if (state_o !== prev) changes++;
    model_next(4'h9);
    vectors++;
    if (changes != 1 || int'(state_o) !== m_state) begin
      miscompares++;
      $display("FAIL hold: got %0d advances to state %0d expected 1 to %0d",
               changes, state_o, m_state);
    end
  endtask

  task automatic test_clear_with_next();
    while (m_state != 2) press(1'b1, 1'b0, 4'($urandom));
    press(1'b1, 1'b1, 4'hF);
    vectors++;
    if (dut.a_r !== '0 || dut.b_r !== '0 || z !== '0 || carry !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_with_next: got a=%0h b=%0h z=%0h c=%0b expected all zero",
               dut.a_r, dut.b_r, z, carry);
    end
  endtask

  task automatic test_reset_mid_add();
    int guard;
    int done_seen;
    while (m_state != 3) press(1'b1, 1'b0, 4'($urandom));
    @(negedge clk);
    y = 4'h6; pb_next = 1'b1;
    guard = 0;
    while (!busy && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (!busy) begin
      miscompares++;
      $display("FAIL reset_mid_add_timeout: busy=%0b expected 1", busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0; pb_next = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    vectors++;
    if ({z, carry, busy, done, state_o} !== {{W{1'b0}}, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_add: got z=%0h c=%0b busy=%0b done=%0b st=%0d expected all zero",
               z, carry, busy, done, state_o);
    end
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) done_seen = 1;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got activity=%0d expected 0", done_seen);
    end
    load_and_add(4'hF, 4'h7, 4'h1, 4'h0, "wrap");
  endtask

  // Fast-debounce instance: next presses landing inside ADD must be ignored.
  task automatic test_next_during_add();
    logic [3:0] n [4];
    int fa, fb, s, guard;
    for (int i = 0; i < 4; i++) n[i] = 4'($urandom);
    fa = int'(n[0]) | ((int'(n[1]) & 7) << 4);
    fb = int'(n[2]) | ((int'(n[3]) & 7) << 4);
    s = fa + fb;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); y_f = n[i]; pbn_f = 1'b1;
      repeat (4) @(negedge clk); pbn_f = 1'b0;
      repeat (4) @(negedge clk);
    end
    @(negedge clk); y_f = n[3]; pbn_f = 1'b1;
    repeat (2) @(negedge clk); pbn_f = 1'b0;
    guard = 0;
    while (!busy_f && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    // Two fresh presses whose pulses arrive while still adding.
    pbn_f = 1'b1; @(negedge clk);
    pbn_f = 1'b0; @(negedge clk);
    pbn_f = 1'b1; @(negedge clk);
    pbn_f = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (done_f !== 1'b1 || state_f !== 3'd5) begin
      miscompares++;
      $display("FAIL next_in_add_state: got done=%0b st=%0d expected 1 5", done_f, state_f);
    end
    vectors++;
    if (int'(z_f) !== s % (1 << W) || int'(carry_f) !== s / (1 << W)) begin
      miscompares++;
      $display("FAIL next_in_add_sum: got z=%0h c=%0b expected z=%0h c=%0d",
               z_f, carry_f, s % (1 << W), s / (1 << W));
    end
  endtask

  initial begin
    test_reset();
    load_and_add(4'h5, 4'h5, 4'hB, 4'h2, "sum_55_2b");
    load_and_add(4'h2, 4'h1, 4'h3, 4'h2, "sum_12_23");
    test_done_return();
    test_random_loads();
    test_done_return();
    test_glitch_and_hold();
    test_clear_with_next();
    test_reset_mid_add();
    test_done_return();
    test_next_during_add();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_load_sequencer.md
Name: adder_load_sequencer

Overview:
- Synchronous controller that loads two 7-bit operands from 4-bit slide switches with a single "next" push button, then runs a bit-serial add.
- Replaces the four asynchronous button-clocked operand registers used on the adder board today.
- Sits between the board pins (switches, buttons) and the LED/seven-segment outputs.
- Contains one full_adder instance time-shared over WIDTH cycles.

Parameters:
- WIDTH, 7, operand width; legal range 5..8; the high part of each operand has WIDTH-4 bits.
- DEBOUNCE_CYCLES, 16, consecutive stable samples required before a button level is accepted; the board build overrides this with 500000.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- pb_next  input  1  raw "next" push button, asynchronous and bouncy.
- pb_clear  input  1  raw "clear" push button, asynchronous and bouncy.
- y  input  4  switch value, captured when a next press is accepted.
- z  output  WIDTH  sum.
- carry  output  1  carry out of the MSB.
- busy  output  1  high while in ADD.
- done  output  1  high while in DONE.
- state_o  output  3  current state encoding, driven to LEDs.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low: rst_n low at a clk edge clears everything.
  - Reset values: z=0, carry=0, busy=0, done=0, state_o=LOAD_A_LO, operand registers a=0 and b=0, bit counter=0, internal carry=0, all debounce state cleared.
- Button conditioning (one pb_debounce per button):
  - Input passes through a 2-flop synchroniser.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive identical samples.
  - A rising edge of the accepted level produces a one-cycle press pulse.
  - Holding the button produces one pulse only.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- State encoding: LOAD_A_LO=0, LOAD_A_HI=1, LOAD_B_LO=2, LOAD_B_HI=3, ADD=4, DONE=5.
- State transitions on a next pulse:
  - LOAD_A_LO: a[3:0]<=y; go to LOAD_A_HI.
  - LOAD_A_HI: a[WIDTH-1:4]<=y[WIDTH-5:0]; go to LOAD_B_LO.
  - LOAD_B_LO: b[3:0]<=y; go to LOAD_B_HI.
  - LOAD_B_HI: b[WIDTH-1:4]<=y[WIDTH-5:0]; clear bit counter and internal carry; go to ADD.
  - DONE: go to LOAD_A_LO. a, b, z and carry hold until overwritten.
- ADD state:
  - Each cycle, bit i = counter: z[i]<=a[i]^b[i]^c and c<=majority(a[i], b[i], c), computed through the full_adder instance; counter increments.
  - After bit WIDTH-1: carry<=final carry-out; go to DONE.
  - A next pulse in ADD is ignored and is not queued.
- Latency: a next pulse accepted in LOAD_B_HI at edge t gives busy=1 from t+1 and done=1 from t+1+WIDTH.
- z contents:
  - During ADD, z holds partially updated bits.
  - z is valid only while done=1.
  - Entering ADD does not pre-clear z; bits are overwritten in order.
- Clear pulse:
  - In any state, go to LOAD_A_LO and zero a, b, z, carry and the counter.
  - If clear and next pulse in the same cycle, clear wins and next is dropped.
- Reset mid-ADD: abort, all registers take their reset values, and no done pulse is produced.
- Wrap-around: the sum is modulo 2^WIDTH, with the overflow reported only on carry. Example: a=0x7F, b=0x01 gives z=0x00, carry=1.

Decomposition:
- Package adder_seq_pkg holds:
  - the state localparams and a 3-bit state type;
  - default WIDTH and DEBOUNCE_CYCLES.
- Sub-module pb_debounce (synchroniser, stability counter, edge pulse), instantiated twice.
- The existing full_adder is reused as the bit-serial cell.

Test Plan:
- Load y=5, 5, 0xB, 2 with clean presses (a=0x55, b=0x2B) -> busy for 7 cycles, then done=1, z=0x00, carry=1.
- Load a=0x12, b=0x23 -> z=0x35, carry=0; done asserted exactly 8 cycles after the fourth accepted press.
- A 3-cycle glitch on pb_next (DEBOUNCE_CYCLES=16) -> no state change; hold pb_next for 100 cycles -> exactly one state advance.
- pb_next pulses during ADD -> ignored, and the result is unchanged. pb_next and pb_clear asserted together in LOAD_B_LO -> state 0, a=b=0.
- rst_n low for one cycle at ADD bit 3 -> next cycle state_o=0, z=0, carry=0, busy=0, done=0; a subsequent full load of a=0x7F, b=0x01 -> z=0x00, carry=1.
- From DONE, press next -> LOAD_A_LO, with z still holding the old sum until the next ADD.
